// File: rtl/wb_pkg.sv
// Shared writeback definitions: channel ranks, default widths and the result payload.
package wb_pkg;
  localparam int unsigned CH_ALU    = 0;
  localparam int unsigned CH_CSR    = 1;
  localparam int unsigned CH_DMEM   = 2;
  localparam int unsigned CH_DIV    = 3;
  localparam int unsigned CH_REM    = 4;
  localparam int unsigned CH_MUL    = 5;
  localparam int unsigned WB_NCH    = 6;
  localparam int unsigned WB_XLEN   = 64;
  localparam int unsigned WB_RIDX_W = 5;

  typedef struct packed {
    logic [WB_RIDX_W-1:0] rd;
    logic [WB_XLEN-1:0]   data;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant among N requesters. Round-robin with a pointer when WB_RR_EN is defined,
// otherwise fixed priority (lowest index wins) with no state.
module rr_arbiter #(
  parameter int unsigned N = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  input  logic         flush,
  output logic [N-1:0] gnt
);
`ifdef WB_RR_EN
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] idx;
  logic          found;

  // Search from ptr upward with wrap; pointer moves past the winner only on a transfer.
  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    idx     = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
        ptr_nxt  = (32'(idx) == N - 1) ? '0 : PW'(32'(idx) + 1);
      end
    end
    if (flush) begin
      gnt     = '0;
      ptr_nxt = ptr;
    end
    if (!advance) ptr_nxt = ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_nxt;
  end
`else
  logic found;
  logic unused_fixed;

  assign unused_fixed = ^{clk, rst_n, advance};

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    if (flush) gnt = '0;
  end
`endif
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one result source per cycle and registers it onto the RF write port.
// Build option: WB_RR_EN selects round-robin arbitration (fixed priority otherwise).
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned NCH    = WB_NCH,
  parameter int unsigned XLEN   = WB_XLEN,
  parameter int unsigned RIDX_W = WB_RIDX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic [NCH-1:0]        src_valid_i,
  input  logic [NCH*RIDX_W-1:0] src_rd_i,
  input  logic [NCH*XLEN-1:0]   src_data_i,
  output logic [NCH-1:0]        src_ready_o,
  output logic                  rf_we_o,
  output logic [RIDX_W-1:0]     rf_waddr_o,
  output logic [XLEN-1:0]       rf_wdata_o,
  output logic [NCH-1:0]        wb_stall_o
);
  logic [NCH-1:0]    gnt;
  logic              advance;
  logic [RIDX_W-1:0] mux_rd;
  logic [XLEN-1:0]   mux_data;
  wb_req_t           sel;

  // Grants are suppressed while in reset so nothing is consumed before the port is live.
  rr_arbiter #(.N(NCH)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (src_valid_i),
    .advance (advance),
    .flush   (flush_i | ~rst_n),
    .gnt     (gnt)
  );

  assign advance     = |gnt;
  assign src_ready_o = gnt;

  // One-hot grant turns the slice select into a plain AND-OR mux.
  always_comb begin
    mux_rd   = '0;
    mux_data = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (gnt[c]) begin
        mux_rd   = mux_rd   | src_rd_i[c*RIDX_W +: RIDX_W];
        mux_data = mux_data | src_data_i[c*XLEN +: XLEN];
      end
    end
    sel.rd   = WB_RIDX_W'(mux_rd);
    sel.data = WB_XLEN'(mux_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      wb_stall_o <= '0;
    end else begin
      rf_we_o    <= advance && (sel.rd != '0);
      wb_stall_o <= src_valid_i & ~gnt & {NCH{~flush_i}};
      if (advance) begin
        rf_waddr_o <= RIDX_W'(sel.rd);
        rf_wdata_o <= XLEN'(sel.data);
      end
    end
  end
endmodule
